// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
// Included by every file in the mem_arbiter slice.
package mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    A_OWN,
    B_OWN
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Master/RAM bundle for mem_arbiter: two request ports plus RAM side.
// slave = arbiter view, master = requesters and RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) ();
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the port that did not win last
// time is chosen. Output is one-hot {b, a}.
module rr_pick
  import mem_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  port_t      last_gnt,
  output logic [1:0] gnt
);

  // one-hot grant from requests and previous winner
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req_a & req_b):
        gnt = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
      (req_a & ~req_b): gnt = 2'b01;
      (~req_a & req_b): gnt = 2'b10;
      default:          gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with short lock sharing one single-port RAM.
// Optional grant/conflict counters: define MEM_ARBITER_STATS_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0] a_gnt_cnt,
  output logic [15:0] b_gnt_cnt,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(LOCK_MAX - 1);

  arb_state_t state, state_nxt;
  port_t      last_gnt, last_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [1:0] pick;
  logic       a_g, b_g;
  logic       a_rv_q, b_rv_q;

  rr_pick u_pick (
    .req_a    (bus.a_req),
    .req_b    (bus.b_req),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // grant decision: picker when idle, owner only while locked
  always_comb begin
    a_g = 1'b0;
    b_g = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    {b_g, a_g} = pick;
        A_OWN:   a_g = bus.a_req;
        B_OWN:   b_g = bus.b_req;
        default: ;
      endcase
    end
  end

  // RAM command mux, parked at zero with no grant
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    unique case (1'b1)
      a_g: begin
        bus.mem_we   = bus.a_we;
        bus.mem_addr = bus.a_addr;
        bus.mem_din  = bus.a_wdata;
      end
      b_g: begin
        bus.mem_we   = bus.b_we;
        bus.mem_addr = bus.b_addr;
        bus.mem_din  = bus.b_wdata;
      end
      default: ;
    endcase
  end

  // ownership next-state, hold counter and last winner
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_gnt;
    if (a_g) last_nxt = PORT_A;
    if (b_g) last_nxt = PORT_B;
    unique case (state)
      IDLE: begin
        hold_nxt = 4'd0;
        if (a_g && bus.a_lock)
          state_nxt = A_OWN;
        else if (b_g && bus.b_lock)
          state_nxt = B_OWN;
      end
      A_OWN: begin
        hold_nxt = hold_cnt + 4'd1;
        if (!bus.a_lock || hold_cnt == HOLD_LAST)
          state_nxt = IDLE;
      end
      B_OWN: begin
        hold_nxt = hold_cnt + 4'd1;
        if (!bus.b_lock || hold_cnt == HOLD_LAST)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state registers and read-valid pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= PORT_B;
      hold_cnt <= 4'd0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_nxt;
      hold_cnt <= hold_nxt;
      a_rv_q   <= a_g & ~bus.a_we;
      b_rv_q   <= b_g & ~bus.b_we;
    end
  end

  assign bus.a_gnt    = a_g;
  assign bus.b_gnt    = b_g;
  assign bus.a_rvalid = a_rv_q & ~reset;
  assign bus.b_rvalid = b_rv_q & ~reset;
  assign bus.a_rdata  = bus.mem_dout;
  assign bus.b_rdata  = bus.mem_dout;

`ifdef MEM_ARBITER_STATS_EN
  // saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (reset) begin
      a_gnt_cnt    <= 16'd0;
      b_gnt_cnt    <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      a_gnt_cnt    <= sat_inc(a_gnt_cnt, a_g);
      b_gnt_cnt    <= sat_inc(b_gnt_cnt, b_g);
      conflict_cnt <= sat_inc(conflict_cnt,
                              bus.a_req & bus.b_req);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a RAM model and a
// behavioural arbitration reference (directed steps then random).
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] a_gnt_cnt, b_gnt_cnt, conflict_cnt;
`endif

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .a_gnt_cnt    (a_gnt_cnt),
    .b_gnt_cnt    (b_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout      <= bus.mem_din;
    end else begin
      bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] shadow [1024];
  int owner = 0;
  int lock_left = 0;
  bit last_a = 1'b0;
  bit pa_v, pb_v;
  logic [DW-1:0] pa_d, pb_d;
  int cnt_a, cnt_b, cnt_c;

  logic obs_ga, obs_gb, obs_arv, obs_brv;
  logic [DW-1:0] obs_ard, obs_brd;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    bit ga, gb;
    logic ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    @(negedge clk);
    ga = 1'b0;
    gb = 1'b0;
    if (!rst) begin
      if (owner == 1) ga = bus.a_req;
      else if (owner == 2) gb = bus.b_req;
      else if (bus.a_req && bus.b_req) begin
        if (last_a) gb = 1'b1;
        else ga = 1'b1;
      end else begin
        ga = bus.a_req;
        gb = bus.b_req;
      end
    end
    ewe = 1'b0; eaddr = '0; edin = '0;
    if (ga) begin
      ewe = bus.a_we; eaddr = bus.a_addr; edin = bus.a_wdata;
    end
    if (gb) begin
      ewe = bus.b_we; eaddr = bus.b_addr; edin = bus.b_wdata;
    end
    obs_ga = bus.a_gnt;  obs_gb = bus.b_gnt;
    obs_arv = bus.a_rvalid; obs_brv = bus.b_rvalid;
    obs_ard = bus.a_rdata;  obs_brd = bus.b_rdata;
    chk("a_gnt", 32'(bus.a_gnt), 32'(ga));
    chk("b_gnt", 32'(bus.b_gnt), 32'(gb));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
    chk("mem_din", 32'(bus.mem_din), 32'(edin));
    chk("a_rvalid", 32'(bus.a_rvalid), 32'(!rst && pa_v));
    chk("b_rvalid", 32'(bus.b_rvalid), 32'(!rst && pb_v));
    if (!rst && pa_v) chk("a_rdata", 32'(bus.a_rdata), 32'(pa_d));
    if (!rst && pb_v) chk("b_rdata", 32'(bus.b_rdata), 32'(pb_d));
`ifdef MEM_ARBITER_STATS_EN
    chk("a_gnt_cnt", 32'(a_gnt_cnt), 32'(cnt_a));
    chk("b_gnt_cnt", 32'(b_gnt_cnt), 32'(cnt_b));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt_c));
`endif
    @(posedge clk);
    if (rst) begin
      owner = 0; last_a = 1'b0; pa_v = 1'b0; pb_v = 1'b0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
    end else begin
      if (bus.a_req && bus.b_req && cnt_c < 16'hFFFF) cnt_c++;
      if (ga && cnt_a < 16'hFFFF) cnt_a++;
      if (gb && cnt_b < 16'hFFFF) cnt_b++;
      pa_v = ga && !bus.a_we;
      pb_v = gb && !bus.b_we;
      pa_d = shadow[bus.a_addr];
      pb_d = shadow[bus.b_addr];
      if (ga && bus.a_we) shadow[bus.a_addr] = bus.a_wdata;
      if (gb && bus.b_we) shadow[bus.b_addr] = bus.b_wdata;
      if (ga) last_a = 1'b1;
      if (gb) last_a = 1'b0;
      if (owner == 0) begin
        if (ga && bus.a_lock) begin
          owner = 1; lock_left = LOCK_MAX;
        end else if (gb && bus.b_lock) begin
          owner = 2; lock_left = LOCK_MAX;
        end
      end else begin
        lock_left--;
        if ((owner == 1 ? !bus.a_lock : !bus.b_lock) ||
            lock_left == 0)
          owner = 0;
      end
    end
    #1;
  endtask

  task automatic set_a(logic req, logic we, logic lk,
                       logic [AW-1:0] ad, logic [DW-1:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_lock = lk;
    bus.a_addr = ad; bus.a_wdata = wd;
  endtask

  task automatic set_b(logic req, logic we, logic lk,
                       logic [AW-1:0] ad, logic [DW-1:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_lock = lk;
    bus.b_addr = ad; bus.b_wdata = wd;
  endtask

  task automatic do_reset();
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    pa_v = 0; pb_v = 0; pa_d = 0; pb_d = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    set_a(1, 1, 0, 10'd7, 16'h1234);
    set_b(1, 0, 0, 10'd9, 16'h0);
    rst = 1'b1;
    step();
    chk("rst_a_gnt", 32'(obs_ga), 0);
    chk("rst_b_gnt", 32'(obs_gb), 0);
    step();

    // write then read address 5 from A
    do_reset();
    set_a(1, 1, 0, 10'd5, 16'h00AA);
    step();
    chk("t1_wr_gnt", 32'(obs_ga), 1);
    set_a(1, 0, 0, 10'd5, 16'h0);
    step();
    chk("t1_rd_gnt", 32'(obs_ga), 1);
    set_a(0, 0, 0, 0, 0);
    step();
    chk("t1_rvalid", 32'(obs_arv), 1);
    chk("t1_rdata", 32'(obs_ard), 32'h00AA);

    // dual continuous reads alternate
    do_reset();
    set_a(1, 1, 0, 10'd1, 16'h1111);
    step();
    set_a(0, 0, 0, 0, 0);
    set_b(1, 1, 0, 10'd2, 16'h2222);
    step();
    set_a(1, 0, 0, 10'd1, 16'h0);
    set_b(1, 0, 0, 10'd2, 16'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_a_gnt", 32'(obs_ga), 32'(i % 2 == 0));
      chk("t2_b_gnt", 32'(obs_gb), 32'(i % 2 == 1));
    end
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    step();

    // lock held continuously: 1 + LOCK_MAX grants to A
    do_reset();
    set_a(1, 0, 1, 10'd3, 16'h0);
    set_b(1, 0, 0, 10'd4, 16'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_a_gnt", 32'(obs_ga), 32'(i < 5));
      chk("t3_b_gnt", 32'(obs_gb), 32'(i == 5));
      if (obs_gb) set_b(0, 0, 0, 0, 0);
    end
    set_a(0, 0, 0, 0, 0);
    step();

    // locked read-modify-write not interleaved by B
    do_reset();
    set_a(1, 0, 1, 10'd10, 16'h0);
    set_b(1, 1, 0, 10'd10, 16'hBBBB);
    step();
    chk("t4_rd_a", 32'(obs_ga), 1);
    set_a(1, 1, 0, 10'd10, 16'd101);
    step();
    chk("t4_wr_a", 32'(obs_ga), 1);
    chk("t4_wr_b", 32'(obs_gb), 0);
    set_a(0, 0, 0, 0, 0);
    step();
    chk("t4_b_gnt", 32'(obs_gb), 1);
    set_b(0, 0, 0, 0, 0);
    set_a(1, 0, 0, 10'd10, 16'h0);
    step();
    set_a(0, 0, 0, 0, 0);
    step();
    chk("t4_final", 32'(obs_ard), 32'hBBBB);

    // reset right after a B read grant drops the read
    do_reset();
    set_b(1, 0, 0, 10'd2, 16'h0);
    step();
    chk("t5_b_gnt", 32'(obs_gb), 1);
    set_b(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("t5_rv_rst", 32'(obs_brv), 0);
    rst = 1'b0;
    step();
    chk("t5_rv_after", 32'(obs_brv), 0);
    set_a(1, 0, 0, 10'd1, 16'h0);
    set_b(1, 0, 0, 10'd2, 16'h0);
    step();
    chk("t5_tie_a", 32'(obs_ga), 1);

`ifdef MEM_ARBITER_STATS_EN
    do_reset();
    set_a(1, 0, 0, 10'd1, 16'h0);
    set_b(1, 0, 0, 10'd2, 16'h0);
    for (int i = 0; i < 8; i++) step();
    chk("st_conflict", 32'(conflict_cnt), 8);
    chk("st_a_cnt", 32'(a_gnt_cnt), 4);
    chk("st_b_cnt", 32'(b_gnt_cnt), 4);
`endif

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      step();
      if (!bus.a_req || obs_ga)
        set_a(1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0),
              AW'($urandom_range(0, 15)),
              DW'($urandom));
      if (!bus.b_req || obs_gb)
        set_b(1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) == 0),
              AW'($urandom_range(0, 15)),
              DW'($urandom));
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 data RAM between two requesters: port A (CPU load/store path) and port B (secondary master: program loader, I/O, or display fetch).
- Round-robin arbitration with an optional short lock, so port A can do read-modify-write sequences without being interleaved.
- Sits between the masters and the RAM. RAM writes on the clock edge, has 1-cycle registered read data, and is write-through on write.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 16, RAM data width.
- LOCK_MAX, 4, maximum consecutive cycles a port may hold a lock; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request; held until a_gnt.
- a_we  in  1  port A write (1) / read (0).
- a_lock  in  1  port A requests ownership after this grant.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A access issued this cycle (combinational).
- a_rvalid  out  1  port A read data valid (registered).
- a_rdata  out  DATA_W  port A read data (= mem_dout).
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A signals, for port B.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data (the RAM's data_in).
- mem_dout  in  DATA_W  RAM read data (the RAM's data_out).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE, last_gnt=B (so A wins the first tie), hold_cnt=0.
  - a_rvalid=b_rvalid=0.
  - While reset is high: a_gnt=b_gnt=mem_we=0, mem_addr=0, mem_din=0.
- Access issue:
  - At most one access per cycle.
  - The granted port's we/addr/wdata are muxed combinationally to mem_*.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0.
- Read latency:
  - A read granted in cycle N gives x_rvalid=1 in cycle N+1, with x_rdata=mem_dout.
  - Writes never raise rvalid.
  - Back-to-back reads from one port are allowed (one per cycle).
- Masters hold req/we/addr/wdata stable until their gnt is sampled high. No grant is issued without req.
- State IDLE:
  - Only one port requesting: grant it.
  - Both requesting: grant the port that is not last_gnt.
  - On any grant, update last_gnt.
  - Granted port has its lock high: next state is A_OWN or B_OWN, hold_cnt=0.
- State A_OWN (B_OWN mirrors):
  - A is granted whenever a_req is high; B is never granted.
  - hold_cnt increments every cycle.
  - Next state is IDLE if a_lock=0 or hold_cnt==LOCK_MAX-1 (forced release); otherwise stay.
  - After a forced release, last_gnt=A, so a pending B wins the next tie.
- Simultaneous events:
  - lock is sampled only with a grant. Lock asserted without req has no effect in IDLE.
  - A port holding its own lock low while in OWN releases in that same cycle's next-state decision.
- Reset mid-operation: any in-flight read is dropped (rvalid stays 0) and ownership is cleared.
- Write-through: a RAM write makes mem_dout = written data next cycle, but no rvalid is raised for it.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined:
  - Adds outputs a_gnt_cnt, b_gnt_cnt, conflict_cnt, each 16-bit and saturating at 16'hFFFF, all reset to 0.
  - conflict_cnt increments every cycle where a_req and b_req are both high and only one (or neither) is granted.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W constants;
  - arb_state_t enum (IDLE, A_OWN, B_OWN);
  - port-select encoding (PORT_A=0, PORT_B=1).
- One natural sub-module: rr_pick, a 2-way round-robin picker (inputs: req_a, req_b, last_gnt; outputs: one-hot grant). Combinational; state stays in mem_arbiter.

Test Plan:
- After reset, A writes 16'h00AA to address 5 and then reads address 5 -> a_gnt high each cycle; a_rvalid=1 in the cycle after the read grant, a_rdata=16'h00AA.
- A and B both request reads every cycle (A addr 1, B addr 2) -> grants alternate A,B,A,B; each rvalid follows its grant by one cycle; rdata matches RAM contents.
- A lock held with a_req continuous, B requesting, LOCK_MAX=4 -> A granted 5 consecutive cycles (IDLE grant + 4 OWN), then B granted.
- A locked read-modify-write of address 10 (read, then write 16'd101), B writes address 10 meanwhile -> B's grant comes only after A's write; final RAM[10] equals B's data.
- Reset asserted the cycle after a B read grant -> b_rvalid stays 0; state returns to IDLE; the next tie is granted to A.
- With MEM_ARBITER_STATS_EN: 8 cycles of dual requests -> conflict_cnt=8, a_gnt_cnt=4, b_gnt_cnt=4.
